piso_shift_tx: RTL

Parallel-in/serial-out transmitter: the read-out side of our N-bit parallel registers.
- Accepts one N-bit word via a start/ready handshake.
- Shifts the word out MSB-first on a single serial line, each bit held for a programmable number of clock cycles.
- Signals completion with a one-cycle done pulse.
- Sits between a parallel data register and any serial link or serial-in receiver.

---
 rtl/piso_shift_tx_if.sv | 30 +++
 rtl/piso_shift_tx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: handshake and serial bundle for piso_shift_tx.
// master drives start/din; slave returns ready, sout, sout_valid, done.
interface piso_shift_tx_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] din;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    modport master (
        output start,
        output din,
        input  ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  start,
        input  din,
        output ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter, MSB first, each bit
// held BIT_TICKS cycles, then a one-cycle done pulse.
// Ports: clk; reset (synchronous, active-low);
//   bus (piso_shift_tx_if.slave): start, din in; ready, sout,
//   sout_valid, done out. All outputs decode from registered state.
// Option: define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit.
module piso_shift_tx #(
    parameter int N         = 4,
    parameter int BIT_TICKS = 1
) (
    input  logic           clk,
    input  logic           reset,
    piso_shift_tx_if.slave bus
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

`ifdef PISO_SHIFT_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
`endif

    state_t        state;
    state_t        state_d;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_d;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_d;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_d;
    logic          tick_last;
    logic          sout_d;

`ifdef PISO_SHIFT_TX_PARITY_EN
    logic          par_q;
    logic          par_d;
`endif

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_d;
            tick_cnt <= tick_d;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // With BIT_TICKS==1 TICK_LAST is 0, so tick_last is always true
    // and the tick counter never leaves 0.
    assign tick_last = (tick_cnt == TICK_LAST);

    // Next-state logic
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        bit_d   = bit_cnt;
        tick_d  = tick_cnt;
`ifdef PISO_SHIFT_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_d = bus.din;
                    bit_d   = '0;
                    tick_d  = '0;
                    state_d = SHIFT;
`ifdef PISO_SHIFT_TX_PARITY_EN
                    par_d   = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shreg_d = {shreg[N-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
            end
`ifdef PISO_SHIFT_TX_PARITY_EN
            PARITY: begin
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = DONE;
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        sout_d = 1'b0;
        unique case (state)
            SHIFT:   sout_d = shreg[N-1];
`ifdef PISO_SHIFT_TX_PARITY_EN
            PARITY:  sout_d = par_q;
`endif
            default: sout_d = 1'b0;
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.sout  = sout_d;
`ifdef PISO_SHIFT_TX_PARITY_EN
    assign bus.sout_valid = (state == SHIFT) || (state == PARITY);
`else
    assign bus.sout_valid = (state == SHIFT);
`endif

endmodule
